// File: rtl/fill_counter.sv
// Multi-channel fill/drain counter with terminal-count detection, a done pulse,
// a registered all-done flag and a sticky per-channel underflow flag.
module fill_counter #(
    parameter int NCH  = 4,
    parameter int W    = 4,
    parameter int TERM = 2,
    parameter int WRAP = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   fill_rst,
    input  logic [NCH-1:0]   fill_cnt,
    input  logic [NCH-1:0]   drain_cnt,
    output logic [NCH*W-1:0] q,
    output logic [NCH-1:0]   cnt_done,
    output logic [NCH-1:0]   done_pulse,
    output logic             all_done,
    output logic [NCH-1:0]   err_uflow
);

    if (TERM < 1 || TERM >= (1 << W)) begin : g_bad_term
        $error("fill_counter: TERM must lie in 1 .. 2**W-1");
    end

    localparam logic [W-1:0] TERM_V = W'(TERM);
    localparam logic [W-1:0] ONE_V  = W'(1);
    localparam logic [W-1:0] ZERO_V = '0;

    logic [W-1:0]   cnt_q [NCH];
    logic [W-1:0]   cnt_d [NCH];
    logic [NCH-1:0] cnt_done_q, cnt_done_d;
    logic [NCH-1:0] done_pulse_q, done_pulse_d;
    logic [NCH-1:0] err_uflow_q, err_uflow_d;
    logic           all_done_q, all_done_d;

    always_comb begin
        cnt_done_d   = '0;
        done_pulse_d = '0;
        err_uflow_d  = err_uflow_q;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (fill_rst[i]) begin
                cnt_d[i]       = ZERO_V;
                err_uflow_d[i] = 1'b0;
            end else if (fill_cnt[i] && !drain_cnt[i]) begin
                if (cnt_q[i] < TERM_V) begin
                    cnt_d[i]        = cnt_q[i] + ONE_V;
                    done_pulse_d[i] = (cnt_q[i] + ONE_V) == TERM_V;
                end else if (WRAP != 0) begin
                    // Wrapping counts as an event of its own, hence the pulse.
                    cnt_d[i]        = ZERO_V;
                    done_pulse_d[i] = 1'b1;
                end
            end else if (drain_cnt[i] && !fill_cnt[i]) begin
                if (cnt_q[i] != ZERO_V) begin
                    cnt_d[i] = cnt_q[i] - ONE_V;
                end else begin
                    err_uflow_d[i] = 1'b1;
                end
            end
            cnt_done_d[i] = (cnt_d[i] == TERM_V);
        end
        // Built from next-state bits so all_done lines up with cnt_done.
        all_done_d = &cnt_done_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= ZERO_V;
            end
            cnt_done_q   <= '0;
            done_pulse_q <= '0;
            err_uflow_q  <= '0;
            all_done_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            cnt_done_q   <= cnt_done_d;
            done_pulse_q <= done_pulse_d;
            err_uflow_q  <= err_uflow_d;
            all_done_q   <= all_done_d;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_q
        assign q[g*W +: W] = cnt_q[g];
    end

    assign cnt_done   = cnt_done_q;
    assign done_pulse = done_pulse_q;
    assign err_uflow  = err_uflow_q;
    assign all_done   = all_done_q;

endmodule

// File: tb/tb_fill_counter.sv
// Directed-vector bench for fill_counter: default saturating config, a wrapping
// config, and the single-bit corner in both terminal-count modes.
module tb_fill_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A: defaults (NCH=4, W=4, TERM=2, saturate)
    logic        a_rst;
    logic [3:0]  a_frst, a_fill, a_drain;
    logic [15:0] a_q;
    logic [3:0]  a_done, a_pulse, a_uflow;
    logic        a_all;

    fill_counter u_a (
        .clk(clk), .rst(a_rst), .fill_rst(a_frst), .fill_cnt(a_fill), .drain_cnt(a_drain),
        .q(a_q), .cnt_done(a_done), .done_pulse(a_pulse), .all_done(a_all), .err_uflow(a_uflow)
    );

    // B: TERM=3, wrapping
    logic        b_rst;
    logic [3:0]  b_frst, b_fill, b_drain;
    logic [15:0] b_q;
    logic [3:0]  b_done, b_pulse, b_uflow;
    logic        b_all;

    fill_counter #(.NCH(4), .W(4), .TERM(3), .WRAP(1)) u_b (
        .clk(clk), .rst(b_rst), .fill_rst(b_frst), .fill_cnt(b_fill), .drain_cnt(b_drain),
        .q(b_q), .cnt_done(b_done), .done_pulse(b_pulse), .all_done(b_all), .err_uflow(b_uflow)
    );

    // C (wrap) and D (saturate): NCH=1, W=1, TERM=1, sharing one set of inputs
    logic c_rst;
    logic [0:0] c_frst, c_fill, c_drain;
    logic [0:0] c_q, c_done, c_pulse, c_uflow, d_q, d_done, d_pulse, d_uflow;
    logic c_all, d_all;

    fill_counter #(.NCH(1), .W(1), .TERM(1), .WRAP(1)) u_c (
        .clk(clk), .rst(c_rst), .fill_rst(c_frst), .fill_cnt(c_fill), .drain_cnt(c_drain),
        .q(c_q), .cnt_done(c_done), .done_pulse(c_pulse), .all_done(c_all), .err_uflow(c_uflow)
    );

    fill_counter #(.NCH(1), .W(1), .TERM(1), .WRAP(0)) u_d (
        .clk(clk), .rst(c_rst), .fill_rst(c_frst), .fill_cnt(c_fill), .drain_cnt(c_drain),
        .q(d_q), .cnt_done(d_done), .done_pulse(d_pulse), .all_done(d_all), .err_uflow(d_uflow)
    );

    int b_qexp [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
    int b_pexp [8] = '{0, 0, 1, 1, 0, 0, 1, 1};
    int b_dexp [8] = '{0, 0, 1, 0, 0, 0, 1, 0};

    initial begin
        a_rst = 1; a_frst = 0; a_fill = 0; a_drain = 0;
        b_rst = 1; b_frst = 0; b_fill = 0; b_drain = 0;
        c_rst = 1; c_frst = 0; c_fill = 0; c_drain = 0;
        tick();
        a_rst = 0; b_rst = 0; c_rst = 0;

        // Reset state
        chk("rst_q", a_q, 16'h0000);
        chk("rst_done", a_done, 4'h0);
        chk("rst_pulse", a_pulse, 4'h0);
        chk("rst_all", a_all, 1'b0);
        chk("rst_uflow", a_uflow, 4'h0);

        // Channel 0 fills to TERM=2 then saturates
        a_fill = 4'b0001;
        tick();
        chk("f1_q0", a_q[3:0], 4'd1);
        chk("f1_done", a_done, 4'b0000);
        chk("f1_pulse", a_pulse, 4'b0000);
        tick();
        chk("f2_q0", a_q[3:0], 4'd2);
        chk("f2_done", a_done, 4'b0001);
        chk("f2_pulse", a_pulse, 4'b0001);
        tick();
        chk("f3_q0", a_q[3:0], 4'd2);
        chk("f3_done", a_done, 4'b0001);
        chk("f3_pulse", a_pulse, 4'b0000);

        // Channel 2: hold on fill+drain, drain to 0, underflow sticky, cleared by fill_rst
        a_fill = 4'b0100;
        tick();
        chk("c2_q1", a_q[11:8], 4'd1);
        a_fill = 4'b0100; a_drain = 4'b0100;
        tick();
        chk("c2_hold_q", a_q[11:8], 4'd1);
        chk("c2_hold_pulse", a_pulse, 4'b0000);
        chk("c2_hold_uflow", a_uflow, 4'b0000);
        a_fill = 0;
        tick();
        chk("c2_dr1_q", a_q[11:8], 4'd0);
        chk("c2_dr1_uflow", a_uflow, 4'b0000);
        tick();
        chk("c2_dr2_q", a_q[11:8], 4'd0);
        chk("c2_dr2_uflow", a_uflow, 4'b0100);
        a_drain = 0;
        tick();
        chk("c2_sticky", a_uflow, 4'b0100);
        a_frst = 4'b0100;
        tick();
        chk("c2_frst_uflow", a_uflow, 4'b0000);
        chk("c2_frst_q", a_q, 16'h0002);
        a_frst = 0;

        // Staggered fill of remaining channels; all_done coincident with last cnt_done
        a_fill = 4'b1010;
        tick();
        chk("st1_q", a_q, 16'h1012);
        chk("st1_all", a_all, 1'b0);
        a_fill = 4'b0010;
        tick();
        chk("st2_done", a_done, 4'b0011);
        a_fill = 4'b1100;
        tick();
        chk("st3_done", a_done, 4'b1011);
        chk("st3_all", a_all, 1'b0);
        a_fill = 4'b0100;
        tick();
        chk("st4_done", a_done, 4'b1111);
        chk("st4_all", a_all, 1'b1);
        chk("st4_pulse", a_pulse, 4'b0100);
        a_fill = 0; a_drain = 4'b0001;
        tick();
        chk("st5_q", a_q, 16'h2221);
        chk("st5_done", a_done, 4'b1110);
        chk("st5_all", a_all, 1'b0);
        a_drain = 0;

        // rst + fill_rst + fill all-ones from q=1 everywhere
        a_rst = 1;
        tick();
        a_rst = 0; a_fill = 4'b1111;
        tick();
        chk("r1_q", a_q, 16'h1111);
        a_rst = 1; a_frst = 4'b1111;
        tick();
        chk("r2_q", a_q, 16'h0000);
        chk("r2_done", a_done, 4'b0000);
        a_rst = 0; a_frst = 0; a_fill = 4'b1000;
        tick();
        chk("r3_q3", a_q[15:12], 4'd1);
        a_rst = 1;
        tick();
        chk("r4_q3", a_q[15:12], 4'd0);
        a_rst = 0;
        tick();
        chk("r5_q3", a_q[15:12], 4'd1);
        tick();
        chk("r6_q3", a_q[15:12], 4'd2);
        chk("r6_pulse", a_pulse, 4'b1000);
        // fill_rst on one channel leaves another's fill untouched
        a_fill = 4'b1001; a_frst = 4'b1000;
        tick();
        chk("r7_q", a_q, 16'h0001);
        a_fill = 0; a_frst = 0;

        // Wrapping config: channel 1 filled for 8 cycles
        b_fill = 4'b0010;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("wrap_q%0d", k), b_q[7:4], b_qexp[k]);
            chk($sformatf("wrap_pulse%0d", k), b_pulse[1], b_pexp[k]);
            chk($sformatf("wrap_done%0d", k), b_done[1], b_dexp[k]);
        end
        chk("wrap_other", {b_q[15:8], b_q[3:0]}, 12'h000);
        b_fill = 0;

        // Single-bit corner: C toggles with a pulse each cycle, D saturates at 1
        c_fill = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("c_q%0d", k), c_q, (k % 2 == 0) ? 1 : 0);
            chk($sformatf("c_pulse%0d", k), c_pulse, 1);
            chk($sformatf("d_q%0d", k), d_q, 1);
            chk($sformatf("d_pulse%0d", k), d_pulse, (k == 0) ? 1 : 0);
            chk($sformatf("d_all%0d", k), d_all, 1);
        end
        c_fill = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fill_counter.md
FILL_COUNTER -- requirements
Module: fill_counter

Interface
REQ-001 Parameter NCH, default 4: number of independent counter channels, range 1..16.
REQ-002 Parameter W, default 4: count width per channel in bits, range 1..16.
REQ-003 Parameter TERM, default 2: terminal count; legal range 1 <= TERM <= 2^W-1.
REQ-004 Parameter WRAP, default 0: terminal-count behaviour; 0 = saturate at TERM, 1 = wrap to 0 on fill at TERM.
REQ-005 clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset; synchronous, active-high; clears all channels.
REQ-007 fill_rst  input  NCH  per-channel synchronous clear, active-high.
REQ-008 fill_cnt  input  NCH  per-channel increment request.
REQ-009 drain_cnt  input  NCH  per-channel decrement request.
REQ-010 q  output  NCH*W  per-channel count; channel i occupies bits [i*W +: W].
REQ-011 cnt_done  output  NCH  per-channel level; high while the channel count equals TERM.
REQ-012 done_pulse  output  NCH  per-channel one-cycle pulse on each arrival at TERM or on each wrap.
REQ-013 all_done  output  1  high while every cnt_done bit is high.
REQ-014 err_uflow  output  NCH  per-channel sticky flag, set by a drain at count 0.

Function
REQ-015 All outputs shall be registered, or be a pure function of registered state; no combinational path from any input to any output.
REQ-016 Per-channel priority each cycle shall be: rst, then fill_rst[i], then the fill/drain update.
REQ-017 fill_rst[i]=1 shall set q[i]=0, cnt_done[i]=0, done_pulse[i]=0 and err_uflow[i]=0 on the next edge, without affecting other channels.
REQ-018 fill_cnt[i]=1 with drain_cnt[i]=0 and q[i]<TERM shall increment q[i] by 1.
REQ-019 drain_cnt[i]=1 with fill_cnt[i]=0 and q[i]>0 shall decrement q[i] by 1.
REQ-020 fill_cnt[i]=1 with drain_cnt[i]=1 shall hold q[i], with no pulse and no error.
REQ-021 Fill at q[i]==TERM with WRAP=0 shall hold q[i]=TERM, keep cnt_done[i]=1 and produce no done_pulse.
REQ-022 Fill at q[i]==TERM with WRAP=1 shall set q[i]=0 and cnt_done[i]=0, and assert done_pulse[i] for that one cycle.
REQ-023 Drain at q[i]==0 shall hold q[i]=0 and set err_uflow[i]=1; err_uflow[i] stays set until rst or fill_rst[i].
REQ-024 Any update leaving q[i]==TERM from q[i]!=TERM shall assert cnt_done[i] and done_pulse[i] in the same cycle that q[i] shows TERM, i.e. latency 1 from the request edge.
REQ-025 done_pulse[i] shall be high for exactly one cycle per event and low on every other cycle.
REQ-026 cnt_done[i] shall equal (q[i]==TERM) on every cycle.
REQ-027 all_done shall be the registered AND of the next-state cnt_done bits, so it stays coincident with cnt_done.
REQ-028 Arithmetic shall be unsigned W-bit; q[i] shall never exceed TERM.
REQ-029 Channels shall be fully independent; simultaneous events on different channels shall all take effect in the same cycle.
REQ-030 An illegal TERM (0, or >= 2^W) shall be rejected at elaboration.

Reset
REQ-031 rst=1 shall, on the next edge, set all q=0, cnt_done=0, done_pulse=0, all_done=0 and err_uflow=0, regardless of the other inputs.
REQ-032 rst asserted mid-count shall discard in-progress counts; the first edge after rst deasserts shall count normally from 0.
REQ-033 Outputs are undefined before the first rst edge; the bench shall apply rst for at least 1 cycle.

Verification
REQ-034 Defaults, rst, then fill_cnt[0]=1 for 3 cycles -> q0 goes 1,2,2; cnt_done[0] rises with q0=2; done_pulse[0] high one cycle only.
REQ-035 WRAP=1, TERM=3, fill_cnt[1] held 8 cycles -> q1 goes 1,2,3,0,1,2,3,0; done_pulse[1] high at each q1=3 and each q1=0 cycle.
REQ-036 q2=1, then fill_cnt[2]=drain_cnt[2]=1 -> q2 holds 1; then drain twice -> q2=0, then err_uflow[2]=1 (sticky); then fill_rst[2] -> err_uflow[2]=0.
REQ-037 All channels filled to TERM with staggered timing -> all_done rises on the same cycle as the last cnt_done; a drain on any channel drops all_done the next cycle.
REQ-038 rst and fill_rst asserted together with fill_cnt=all-ones on q=1 -> all q=0 next cycle; rst pulsed mid-count on channel 3 -> q3=0, then the count resumes from 1.
REQ-039 NCH=1, W=1, TERM=1 corner -> q toggles 0,1 with WRAP=1 and saturates at 1 with WRAP=0; elaboration with TERM=2 and W=1 fails.
